// File: rtl/call_scheduler.sv
// Pending-call store and direction scheduler that sits directly ahead of the elevator FSM.
// It latches request pulses, clears the calls served by an open door, and steers the car up or down.
module call_scheduler #(
    parameter int FLOORS  = 8,
    parameter int FLOOR_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [FLOORS-1:0]  up_req,
    input  logic [FLOORS-1:0]  down_req,
    input  logic [FLOORS-1:0]  car_req,
    input  logic [FLOOR_W-1:0] floor,
    input  logic [3:0]         status,
    output logic [FLOORS-1:0]  up_call,
    output logic [FLOORS-1:0]  down_call,
    output logic [FLOORS-1:0]  car_call,
    output logic               nextup,
    output logic               nextdown,
    output logic               stop_here,
    output logic [1:0]         dir
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GO_UP   = 2'b01,
        GO_DOWN = 2'b10
    } dir_t;

    dir_t              dir_q, dir_d;
    logic [FLOORS-1:0] at_f, above_mask, below_mask;
    logic [FLOORS-1:0] up_set, down_set, car_set, any_set;
    logic [FLOORS-1:0] up_d, down_d, car_d;
    logic              above, below, door_open, clr_up, clr_down, stop_d;
    logic              unused_status;

    assign door_open     = status[1];
    assign unused_status = ^{status[3:2], status[0]};

    // An out-of-range floor matches no bit, so it clears nothing and sees nothing above.
    always_comb begin
        at_f       = '0;
        above_mask = '0;
        below_mask = '0;
        for (int i = 0; i < FLOORS; i++) begin
            at_f[i]       = (int'(floor) == i);
            above_mask[i] = (i > int'(floor));
            below_mask[i] = (i < int'(floor));
        end
    end

    // Clearing only touches the bit at the current floor, so above/below of the
    // set vectors equal above/below of the next-state vectors.
    always_comb begin
        up_set   = up_call | up_req;
        down_set = down_call | down_req;
        car_set  = car_call | car_req;
        any_set  = up_set | down_set | car_set;
        above    = |(any_set & above_mask);
        below    = |(any_set & below_mask);
        clr_up   = door_open & ((dir_q != GO_DOWN) | ~below);
        clr_down = door_open & ((dir_q != GO_UP) | ~above);
        up_d     = up_set   & ~(clr_up    ? at_f : '0);
        down_d   = down_set & ~(clr_down  ? at_f : '0);
        car_d    = car_set  & ~(door_open ? at_f : '0);
    end

    always_comb begin
        dir_d = dir_q;
        case (dir_q)
            GO_DOWN: begin
                if (below)      dir_d = GO_DOWN;
                else if (above) dir_d = GO_UP;
                else            dir_d = IDLE;
            end
            default: begin
                if (above)      dir_d = GO_UP;
                else if (below) dir_d = GO_DOWN;
                else            dir_d = IDLE;
            end
        endcase
    end

    always_comb begin
        stop_d = (|(car_d & at_f))
               | ((dir_d == GO_UP)   & (|(up_d & at_f)))
               | ((dir_d == GO_DOWN) & (|(down_d & at_f)))
               | ((dir_d == IDLE)    & (|((up_d | down_d) & at_f)))
               | ((dir_d == GO_UP)   & (|(down_d & at_f)) & ~above)
               | ((dir_d == GO_DOWN) & (|(up_d & at_f)) & ~below);
        if (door_open) stop_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            up_call   <= '0;
            down_call <= '0;
            car_call  <= '0;
            nextup    <= 1'b0;
            nextdown  <= 1'b0;
            stop_here <= 1'b0;
            dir_q     <= IDLE;
        end else begin
            up_call   <= up_d;
            down_call <= down_d;
            car_call  <= car_d;
            nextup    <= above;
            nextdown  <= below;
            stop_here <= stop_d;
            dir_q     <= dir_d;
        end
    end

    assign dir = dir_q;

endmodule

// File: tb/tb_call_scheduler.sv
// Bench for call_scheduler: directed scenarios plus random traffic checked against a queued reference model.
module tb_call_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] up_req = '0, down_req = '0, car_req = '0;
    logic [2:0] floor = '0;
    logic [3:0] status = '0;
    logic [7:0] up_call, down_call, car_call;
    logic       nextup, nextdown, stop_here;
    logic [1:0] dir;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] up;
        logic [7:0] down;
        logic [7:0] car;
        logic       nu;
        logic       nd;
        logic       sh;
        logic [1:0] dir;
    } exp_t;

    exp_t q[$];

    logic [7:0] m_up = '0, m_down = '0, m_car = '0;
    logic [1:0] m_dir = 2'b00;

    call_scheduler #(.FLOORS(8), .FLOOR_W(3)) dut (
        .clk(clk), .rst(rst),
        .up_req(up_req), .down_req(down_req), .car_req(car_req),
        .floor(floor), .status(status),
        .up_call(up_call), .down_call(down_call), .car_call(car_call),
        .nextup(nextup), .nextdown(nextdown), .stop_here(stop_here),
        .dir(dir)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: next registered state from the current model state and this cycle's inputs.
    task automatic model_push(input logic [7:0] u, input logic [7:0] d, input logic [7:0] c,
                              input int fl, input logic [3:0] st);
        logic [7:0] nu, nd, nc;
        logic [1:0] dn;
        bit ab, be, op, sh;
        exp_t e;
        nu = m_up | u;
        nd = m_down | d;
        nc = m_car | c;
        ab = 0;
        be = 0;
        op = st[1];
        for (int i = 0; i < 8; i++) begin
            if (nu[i] | nd[i] | nc[i]) begin
                if (i > fl) ab = 1;
                if (i < fl) be = 1;
            end
        end
        if (op) begin
            nc[fl] = 1'b0;
            if (m_dir == 2'b01) begin
                nu[fl] = 1'b0;
                if (!ab) nd[fl] = 1'b0;
            end else if (m_dir == 2'b10) begin
                nd[fl] = 1'b0;
                if (!be) nu[fl] = 1'b0;
            end else begin
                nu[fl] = 1'b0;
                nd[fl] = 1'b0;
            end
        end
        if (m_dir == 2'b10) dn = be ? 2'b10 : (ab ? 2'b01 : 2'b00);
        else                dn = ab ? 2'b01 : (be ? 2'b10 : 2'b00);
        sh = nc[fl]
           || (dn == 2'b01 && nu[fl]) || (dn == 2'b10 && nd[fl])
           || (dn == 2'b00 && (nu[fl] || nd[fl]))
           || (dn == 2'b01 && nd[fl] && !ab) || (dn == 2'b10 && nu[fl] && !be);
        if (op) sh = 0;
        e.up = nu; e.down = nd; e.car = nc; e.nu = ab; e.nd = be; e.sh = sh; e.dir = dn;
        q.push_back(e);
        m_up = nu; m_down = nd; m_car = nc; m_dir = dn;
    endtask

    task automatic step(input logic [7:0] u, input logic [7:0] d, input logic [7:0] c,
                        input int fl, input logic [3:0] st);
        exp_t e;
        up_req   = u;
        down_req = d;
        car_req  = c;
        floor    = fl[2:0];
        status   = st;
        model_push(u, d, c, fl, st);
        @(posedge clk);
        #1;
        e = q.pop_front();
        check("up_call", up_call, e.up);
        check("down_call", down_call, e.down);
        check("car_call", car_call, e.car);
        check("nextup", {7'b0, nextup}, {7'b0, e.nu});
        check("nextdown", {7'b0, nextdown}, {7'b0, e.nd});
        check("stop_here", {7'b0, stop_here}, {7'b0, e.sh});
        check("dir", {6'b0, dir}, {6'b0, e.dir});
        up_req   = '0;
        down_req = '0;
        car_req  = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_up"}, up_call, 8'h00);
        check({tag, "_down"}, down_call, 8'h00);
        check({tag, "_car"}, car_call, 8'h00);
        check({tag, "_flags"}, {5'b0, nextup, nextdown, stop_here}, 8'h00);
        check({tag, "_dir"}, {6'b0, dir}, 8'h00);
    endtask

    initial begin
        logic [7:0] ru, rd, rc;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Car call above the car sets direction up.
        step(8'h00, 8'h00, 8'h04, 0, 4'b0000);
        check("t1_car", car_call, 8'h04);
        check("t1_nextup", {7'b0, nextup}, 8'h01);
        check("t1_dir", {6'b0, dir}, 8'h01);

        // Hall calls latch; arriving at floor index 1 going up requests a stop.
        step(8'h02, 8'h10, 8'h00, 0, 4'b0000);
        check("t2_up", up_call, 8'h02);
        check("t2_down", down_call, 8'h10);
        step(8'h00, 8'h00, 8'h00, 1, 4'b0000);
        check("t2_stop", {7'b0, stop_here}, 8'h01);

        // Door open at floor index 1 going up with calls above.
        step(8'h00, 8'h00, 8'h00, 1, 4'b0010);
        check("t3_up", up_call, 8'h00);
        check("t3_down", down_call, 8'h10);
        check("t3_stop", {7'b0, stop_here}, 8'h00);

        // Serve car call at 2, then the lone down call at 4 while heading up.
        step(8'h00, 8'h00, 8'h00, 2, 4'b0010);
        step(8'h00, 8'h00, 8'h00, 4, 4'b0010);
        check("t4_down", down_call, 8'h00);
        check("t4_dir", {6'b0, dir}, 8'h00);
        check("t4_next", {6'b0, nextup, nextdown}, 8'h00);

        // Press at the open floor is swallowed; press elsewhere latches.
        step(8'h24, 8'h00, 8'h00, 2, 4'b0010);
        check("t5_up", up_call, 8'h20);

        // Asynchronous reset mid-cycle drops everything.
        step(8'h01, 8'h80, 8'h08, 3, 4'b0000);
        #2 rst = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        rst   = 1'b1;
        m_up  = '0;
        m_down = '0;
        m_car = '0;
        m_dir = 2'b00;
        step(8'h00, 8'h00, 8'h00, 3, 4'b0000);
        check_all_zero("post_rst");

        // Random traffic.
        for (int k = 0; k < 300; k++) begin
            ru = 8'($urandom & $urandom & $urandom);
            rd = 8'($urandom & $urandom & $urandom);
            rc = 8'($urandom & $urandom & $urandom);
            step(ru, rd, rc, $urandom_range(0, 7),
                 ($urandom_range(0, 3) == 0) ? 4'b0010 : 4'b0000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
